// File: rtl/tone_decoder.sv
// ============================================================================
//  Module   : tone_decoder
//  Purpose  : Measures square-wave half-periods and recovers octave/note,
//             with note start/end pulses and note duration.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tone_decoder #(
  parameter int CNT_W          = 24,
  parameter int SILENCE_CYCLES = 8_000_000,
  parameter int STABLE_COUNT   = 4,
  parameter int SCALE          = 0   // right shift applied to all period thresholds
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        tone_in,
  output logic [2:0]  octave,
  output logic [2:0]  note,
  output logic        note_on,
  output logic        note_valid,
  output logic        note_end,
  output logic [31:0] duration,
  output logic        range_err
);

  localparam int              c_RUN_W   = $clog2(STABLE_COUNT + 1);
  localparam logic [c_RUN_W-1:0] c_STABLE = c_RUN_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] c_SILENCE = CNT_W'(SILENCE_CYCLES);
  localparam logic [CNT_W-1:0] c_HI      = CNT_W'(393416 >> SCALE);
  localparam logic [CNT_W-1:0] c_LO      = CNT_W'(196700 >> SCALE);
  localparam logic [CNT_W-1:0] c_THR_C   = CNT_W'(361375 >> SCALE);
  localparam logic [CNT_W-1:0] c_THR_D   = CNT_W'(321950 >> SCALE);
  localparam logic [CNT_W-1:0] c_THR_E   = CNT_W'(294857 >> SCALE);
  localparam logic [CNT_W-1:0] c_THR_F   = CNT_W'(270723 >> SCALE);
  localparam logic [CNT_W-1:0] c_THR_G   = CNT_W'(241188 >> SCALE);
  localparam logic [CNT_W-1:0] c_THR_A   = CNT_W'(214876 >> SCALE);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEASURE  = 2'd1,
    S_NORM     = 2'd2,
    S_CLASSIFY = 2'd3
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic                 r_tone_d;
  logic [CNT_W-1:0]     r_hp_cnt;
  logic [CNT_W-1:0]     r_p;
  logic [2:0]           r_oct;
  logic [c_RUN_W-1:0]   r_run;
  logic [2:0]           r_run_oct;
  logic [2:0]           r_run_note;
  logic [31:0]          r_dur_cnt;
  logic [31:0]          r_last_dur;

  logic                 w_edge;
  logic                 w_timeout;
  logic [2:0]           w_note;
  logic                 w_same;
  logic [c_RUN_W-1:0]   w_run_next;
  logic                 w_accept;

  assign w_edge    = r_sync[1] ^ r_tone_d;
  assign w_timeout = (r_hp_cnt == c_SILENCE);

  always_comb begin
    w_note = 3'd6;
    if      (r_p >= c_THR_C) w_note = 3'd0;
    else if (r_p >= c_THR_D) w_note = 3'd1;
    else if (r_p >= c_THR_E) w_note = 3'd2;
    else if (r_p >= c_THR_F) w_note = 3'd3;
    else if (r_p >= c_THR_G) w_note = 3'd4;
    else if (r_p >= c_THR_A) w_note = 3'd5;
  end

  assign w_same     = (r_run != '0) && (r_oct == r_run_oct) && (w_note == r_run_note);
  assign w_run_next = !w_same ? c_RUN_W'(1) :
                      (r_run >= c_STABLE) ? r_run : r_run + c_RUN_W'(1);
  assign w_accept   = (w_run_next >= c_STABLE) &&
                      (!note_on || ({r_oct, w_note} != {octave, note}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sync     <= '0;
      r_tone_d   <= 1'b0;
      r_hp_cnt   <= '0;
      r_p        <= '0;
      r_oct      <= '0;
      r_run      <= '0;
      r_run_oct  <= '0;
      r_run_note <= '0;
      r_dur_cnt  <= '0;
      r_last_dur <= '0;
      octave     <= '0;
      note       <= '0;
      note_on    <= 1'b0;
      note_valid <= 1'b0;
      note_end   <= 1'b0;
      duration   <= '0;
      range_err  <= 1'b0;
    end else if (!en) begin
      r_state    <= S_IDLE;
      r_sync     <= '0;
      r_tone_d   <= 1'b0;
      r_hp_cnt   <= '0;
      r_p        <= '0;
      r_oct      <= '0;
      r_run      <= '0;
      r_run_oct  <= '0;
      r_run_note <= '0;
      r_dur_cnt  <= '0;
      r_last_dur <= '0;
      octave     <= '0;
      note       <= '0;
      note_on    <= 1'b0;
      note_valid <= 1'b0;
      note_end   <= 1'b0;
      duration   <= '0;
      range_err  <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      note_end   <= 1'b0;
      range_err  <= 1'b0;
      r_sync     <= {r_sync[0], tone_in};
      r_tone_d   <= r_sync[1];

      if (w_edge)          r_hp_cnt <= '0;
      else if (!w_timeout) r_hp_cnt <= r_hp_cnt + 1'b1;

      if (note_on)           r_dur_cnt  <= r_dur_cnt + 32'd1;
      if (w_edge && note_on) r_last_dur <= r_dur_cnt;

      if (w_timeout) begin
        r_state <= S_IDLE;
        r_run   <= '0;
        if (note_on) begin
          note_end <= 1'b1;
          duration <= r_last_dur;
          note_on  <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: if (w_edge) r_state <= S_MEASURE;
          S_MEASURE: begin
            if (w_edge) begin
              r_p     <= r_hp_cnt;
              r_oct   <= 3'd4;
              r_state <= S_NORM;
            end
          end
          // One octave shift per cycle until the period sits in [LO, HI).
          S_NORM: begin
            if (r_p >= c_HI) begin
              if (r_oct == 3'd0) begin
                range_err <= 1'b1;
                r_run     <= '0;
                r_state   <= S_MEASURE;
              end else begin
                r_p   <= r_p >> 1;
                r_oct <= r_oct - 3'd1;
              end
            end else if (r_p < c_LO) begin
              if (r_oct == 3'd7) begin
                range_err <= 1'b1;
                r_run     <= '0;
                r_state   <= S_MEASURE;
              end else begin
                r_p   <= r_p << 1;
                r_oct <= r_oct + 3'd1;
              end
            end else begin
              r_state <= S_CLASSIFY;
            end
          end
          S_CLASSIFY: begin
            r_run      <= w_run_next;
            r_run_oct  <= r_oct;
            r_run_note <= w_note;
            r_state    <= S_MEASURE;
            if (w_accept) begin
              octave     <= r_oct;
              note       <= w_note;
              note_valid <= 1'b1;
              note_on    <= 1'b1;
              r_dur_cnt  <= '0;
              if (note_on) begin
                note_end <= 1'b1;
                duration <= r_last_dur;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tone_decoder.sv
// ============================================================================
//  Module   : tb_tone_decoder
//  Purpose  : Self-checking bench for tone_decoder with scaled-down periods.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tone_decoder;

  localparam int CNT_W   = 16;
  localparam int SIL     = 8000;
  localparam int STABLE  = 4;
  localparam int SCALE   = 10;
  localparam int P_G4    = 255102 >> SCALE;   // 249
  localparam int P_A4    = 227273 >> SCALE;   // 221
  localparam int P_B7    = 25309 >> SCALE;    // 24
  localparam int P_C0    = 6115504 >> SCALE;  // 5972
  localparam int P_BAD   = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        tone_in = 1'b0;
  logic [2:0]  octave;
  logic [2:0]  note;
  logic        note_on;
  logic        note_valid;
  logic        note_end;
  logic [31:0] duration;
  logic        range_err;

  tone_decoder #(
    .CNT_W(CNT_W), .SILENCE_CYCLES(SIL), .STABLE_COUNT(STABLE), .SCALE(SCALE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tone_in(tone_in),
    .octave(octave), .note(note), .note_on(note_on), .note_valid(note_valid),
    .note_end(note_end), .duration(duration), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_valid, n_end, n_both, n_err;
  int t_valid, t_end;
  int end_dur;
  int tog_q[$];

  // Reference decode straight from the octave-normalisation and threshold rules.
  function automatic void model_decode(input int p_in, output int oct, output int nt,
                                       output bit err);
    int p;
    p = p_in; oct = 4; err = 0; nt = 0;
    while (!err && p >= (393416 >> SCALE)) begin
      if (oct == 0) err = 1; else begin p = p / 2; oct = oct - 1; end
    end
    while (!err && p < (196700 >> SCALE)) begin
      if (oct == 7) err = 1; else begin p = p * 2; oct = oct + 1; end
    end
    if      (p >= (361375 >> SCALE)) nt = 0;
    else if (p >= (321950 >> SCALE)) nt = 1;
    else if (p >= (294857 >> SCALE)) nt = 2;
    else if (p >= (270723 >> SCALE)) nt = 3;
    else if (p >= (241188 >> SCALE)) nt = 4;
    else if (p >= (214876 >> SCALE)) nt = 5;
    else                             nt = 6;
  endfunction

  task automatic step(input bit toggle);
    @(posedge clk);
    cyc++;
    #1;
    if (toggle) begin
      tone_in = ~tone_in;
      tog_q.push_back(cyc);
    end
    @(negedge clk);
    if (note_valid) begin n_valid++; t_valid = cyc; end
    if (note_end)   begin n_end++; t_end = cyc; end_dur = int'(duration); end
    if (note_valid && note_end) n_both++;
    if (range_err) n_err++;
  endtask

  // n half-periods, each with hp_cnt = p at its closing edge
  task automatic halves(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (p) step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_end = 0; n_both = 0; n_err = 0;
    t_valid = 0; t_end = 0; end_dur = 0;
    tog_q.delete();
  endtask

  task automatic clear_dut();
    en = 1'b0;
    tone_in = 1'b0;
    step(1'b0);
    step(1'b0);
    en = 1'b1;
    clear_counts();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    #1;
    n_tests++;
    if ({octave, note, note_on, note_valid, note_end, duration, range_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got oct=%0d note=%0d on=%0b dur=%0d expected all zero",
               octave, note, note_on, duration);
    end
    step(1'b0);
    rst_n = 1'b1;
    clear_dut();
  endtask

  task automatic test_g4();
    clear_dut();
    halves(P_G4, 8);
    n_tests++;
    if (n_valid !== 1) begin
      n_fail++; $display("FAIL g4_valid_count: got %0d expected 1", n_valid);
    end
    n_tests++;
    if (t_valid - tog_q[4] < 1 || t_valid - tog_q[4] > 10) begin
      n_fail++; $display("FAIL g4_latency: got %0d cycles expected 1..10", t_valid - tog_q[4]);
    end
    n_tests++;
    if ({octave, note, note_on} !== {3'd4, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL g4_decode: got oct=%0d note=%0d on=%0b expected 4 4 1", octave, note, note_on);
    end
  endtask

  task automatic test_b7_c0();
    clear_dut();
    halves(P_B7, 6);
    n_tests++;
    if ({n_valid[3:0], octave, note, note_on} !== {4'd1, 3'd7, 3'd6, 1'b1}) begin
      n_fail++;
      $display("FAIL b7_decode: got valid=%0d oct=%0d note=%0d on=%0b expected 1 7 6 1",
               n_valid, octave, note, note_on);
    end
    clear_counts();
    halves(P_C0, 5);
    n_tests++;
    if ({n_both[3:0], n_valid[3:0], n_end[3:0]} !== {4'd1, 4'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL c0_replace: got both=%0d valid=%0d end=%0d expected 1 1 1",
               n_both, n_valid, n_end);
    end
    n_tests++;
    if ({octave, note, note_on} !== {3'd0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL c0_decode: got oct=%0d note=%0d on=%0b expected 0 0 1", octave, note, note_on);
    end
  endtask

  task automatic test_silence();
    int exp_dur;
    int dt;
    clear_dut();
    halves(P_G4, 6);
    for (int i = 0; i < SIL + 20 && n_end == 0; i++) step(1'b0);
    dt = t_end - tog_q[$];
    n_tests++;
    if (n_end !== 1 || dt < SIL + 2 || dt > SIL + 4) begin
      n_fail++;
      $display("FAIL silence_end: got %0d pulses at +%0d cycles expected 1 at %0d..%0d",
               n_end, dt, SIL + 2, SIL + 4);
    end
    exp_dur = tog_q[$] - t_valid;
    n_tests++;
    if (end_dur < exp_dur - 3 || end_dur > exp_dur + 3) begin
      n_fail++; $display("FAIL silence_duration: got %0d expected %0d(+/-3)", end_dur, exp_dur);
    end
    n_tests++;
    if ({note_on, octave, note} !== {1'b0, 3'd4, 3'd4}) begin
      n_fail++;
      $display("FAIL silence_state: got on=%0b oct=%0d note=%0d expected 0 4 4", note_on, octave, note);
    end
  endtask

  task automatic test_range();
    clear_dut();
    halves(P_BAD, 6);
    repeat (10) step(1'b0);
    n_tests++;
    if ({n_err[3:0], n_valid[3:0], note_on} !== {4'd5, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL range_err: got err=%0d valid=%0d on=%0b expected 5 0 0", n_err, n_valid, note_on);
    end
  endtask

  task automatic test_alternating();
    clear_dut();
    for (int i = 0; i < 6; i++) begin
      halves(P_G4, 1);
      halves(P_A4, 1);
    end
    n_tests++;
    if ({n_valid[3:0], note_on} !== {4'd0, 1'b0}) begin
      n_fail++; $display("FAIL alternating: got valid=%0d on=%0b expected 0 0", n_valid, note_on);
    end
  endtask

  task automatic test_reset_midnote();
    clear_dut();
    halves(P_G4, 6);
    n_tests++;
    if (note_on !== 1'b1) begin
      n_fail++; $display("FAIL midnote_on: got %0b expected 1", note_on);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({octave, note, note_on, duration} !== '0) begin
      n_fail++; $display("FAIL async_reset: got oct=%0d note=%0d on=%0b expected 0", octave, note, note_on);
    end
    step(1'b0);
    rst_n = 1'b1;
    tone_in = 1'b0;
    clear_counts();
    halves(P_G4, 6);
    n_tests++;
    if ({n_valid[3:0], octave, note, note_on} !== {4'd1, 3'd4, 3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL reaccept_after_reset: got valid=%0d oct=%0d note=%0d expected 1 4 4",
               n_valid, octave, note);
    end
    en = 1'b0;
    step(1'b0);
    n_tests++;
    if ({octave, note, note_on, duration} !== '0) begin
      n_fail++; $display("FAIL en_clear: got oct=%0d note=%0d on=%0b expected 0", octave, note, note_on);
    end
    clear_dut();
    halves(P_G4, 6);
    n_tests++;
    if ({n_valid[3:0], octave, note} !== {4'd1, 3'd4, 3'd4}) begin
      n_fail++;
      $display("FAIL reaccept_after_en: got valid=%0d oct=%0d note=%0d expected 1 4 4",
               n_valid, octave, note);
    end
  endtask

  task automatic test_random_notes();
    int p, m_oct, m_note, exp_v, exp_e;
    bit err;
    bit m_on;
    int cur_oct, cur_note;
    clear_dut();
    m_on = 0; cur_oct = 0; cur_note = 0;
    for (int k = 0; k < 8; k++) begin
      p = int'($urandom_range(400, 24));
      model_decode(p, m_oct, m_note, err);
      exp_v = (!m_on || m_oct != cur_oct || m_note != cur_note) ? 1 : 0;
      exp_e = (exp_v == 1 && m_on) ? 1 : 0;
      clear_counts();
      halves(p, 6);
      m_on = 1; cur_oct = m_oct; cur_note = m_note;
      n_tests++;
      if (n_valid !== exp_v || n_end !== exp_e || n_err !== 0 ||
          octave !== 3'(m_oct) || note !== 3'(m_note) || note_on !== 1'b1) begin
        n_fail++;
        $display("FAIL random_note p=%0d: got valid=%0d end=%0d err=%0d oct=%0d note=%0d on=%0b expected %0d %0d 0 %0d %0d 1",
                 p, n_valid, n_end, n_err, octave, note, note_on, exp_v, exp_e, m_oct, m_note);
      end
    end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_g4();
    test_b7_c0();
    test_silence();
    test_range();
    test_alternating();
    test_reset_midnote();
    test_random_notes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
